ex_mem_flag_stage: RTL and testbench
====================================

// Module: ex_mem_flag_stage
// PURPOSE
//  Consumer side of the 64-bit ALU: captures result + N/Z/V/C outputs into the EX/MEM pipeline register.
//  Holds the architectural NZCV flag register (updated by flag-setting ops, e.g. ADDS/SUBS).
//  Resolves B.cond / CBZ / CBNZ into a registered branch_taken for the fetch stage.
//  Sits between the ALU outputs and the MEM stage of the 5-stage pipe.
// PARAMETERS
//  DATA_W      64  ALU result / datapath width
//  REG_ADDR_W  5   destination register index width
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  in_valid      in   1           an instruction is present at the EX outputs this cycle
//  stall         in   1           hold the stage; no capture, no flag update
//  flush         in   1           kill the instruction being captured
//  alu_result    in   DATA_W      ALU result
//  alu_negative  in   1           ALU N
//  alu_zero      in   1           ALU Z
//  alu_overflow  in   1           ALU V
//  alu_carry_out in   1           ALU C
//  set_flags     in   1           instruction writes NZCV
//  cond_branch   in   1           instruction is B.cond
//  cbz           in   1           instruction is CBZ (ALU runs PASS_B, cntrl=3'b000)
//  cbnz          in   1           instruction is CBNZ (ALU runs PASS_B)
//  cond          in   4           B.cond condition code
//  rd_in         in   REG_ADDR_W  destination register
//  reg_write_in  in   1           instruction writes rd
//  out_valid     out  1           MEM-stage instruction valid
//  result_q      out  DATA_W      registered alu_result
//  rd_q          out  REG_ADDR_W  registered rd_in
//  reg_write_q   out  1           registered reg_write_in (gated by valid)
//  flag_n/z/c/v  out  1 each      architectural NZCV register
//  branch_taken  out  1           registered branch decision for captured instruction
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0, incl. NZCV=0000; rst beats flush and stall.
//  - Accept = in_valid & !stall & !flush. Latency 1 cycle: inputs at edge k appear on outputs after edge k.
//  - On accept: out_valid=1; capture result_q, rd_q; reg_write_q=reg_write_in; branch_taken computed.
//  - stall=1 (no flush): every register holds, incl. NZCV and branch_taken.
//  - flush=1: priority over stall; out_valid, reg_write_q, branch_taken <= 0; NZCV unchanged; result_q/rd_q don't-care.
//  - in_valid=0 (no stall/flush): bubble, out_valid=reg_write_q=branch_taken=0, NZCV held.
//  - NZCV update: on accept & set_flags, {N,Z,C,V} <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
//  - branch_taken on accept:
//      cond_branch -> cond_eval(cond, NZCV register value BEFORE this edge);
//      same-beat set_flags & cond_branch uses OLD flags (not legal ISA, defined anyway);
//      back-to-back SUBS then B.cond: B.cond sees SUBS flags (already registered).
//      cbz -> alu_zero; cbnz -> !alu_zero (ALU Z of PASS_B, not the flag register).
//      none set -> 0. More than one of cond_branch/cbz/cbnz set: priority cond_branch > cbz > cbnz.
//  - cond_eval: EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N;
//      VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V;
//      GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; NV 1111 1.
//  - No arithmetic performed here; widths pass through unchanged.
// STRUCTURE
//  - Shared package/header: ALU cntrl codes (PASS_B=000, ADD=010, SUBTRACT=011, AND=100, OR=101,
//    XOR=110) and the 16 cond-code constants above.
//  - One combinational sub-module: cond_eval(cond[3:0], n, z, c, v) -> taken.
//  - Remainder: one always @(posedge clk) block with rst > flush > stall > accept priority.
// TESTING
//  1 rst=1 two cycles with random inputs -> all outputs 0, NZCV=0000.
//  2 SUBS (alu_result=0, Z=1, C=1, set_flags) then B.cond EQ next cycle -> NZCV=0110, branch_taken=1 after 2nd edge.
//  3 set_flags & cond_branch same beat, cond=EQ, old Z=0, alu_zero=1 -> branch_taken=0, then Z=1.
//  4 CBZ with alu_result=0,alu_zero=1 -> branch_taken=1; CBNZ same inputs -> 0; NZCV unchanged.
//  5 stall=1 three cycles with new inputs -> result_q, rd_q, NZCV, branch_taken frozen;
//    stall=1&flush=1 -> out_valid=0, NZCV unchanged.
//  6 Sweep all 16 cond codes x all 16 NZCV values -> branch_taken matches table; rst mid-stall clears all.

Source files
------------

// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared definitions for the EX/MEM flag stage: ALU control codes, condition codes
// and a small helper for packing the NZCV register.
package ex_mem_flag_stage_pkg;

    typedef enum logic [2:0] {
        AluPassB    = 3'b000,
        AluAdd      = 3'b010,
        AluSubtract = 3'b011,
        AluAnd      = 3'b100,
        AluOr       = 3'b101,
        AluXor      = 3'b110
    } alu_cntrl_e;

    typedef enum logic [3:0] {
        CondEq = 4'b0000,
        CondNe = 4'b0001,
        CondHs = 4'b0010,
        CondLo = 4'b0011,
        CondMi = 4'b0100,
        CondPl = 4'b0101,
        CondVs = 4'b0110,
        CondVc = 4'b0111,
        CondHi = 4'b1000,
        CondLs = 4'b1001,
        CondGe = 4'b1010,
        CondLt = 4'b1011,
        CondGt = 4'b1100,
        CondLe = 4'b1101,
        CondAl = 4'b1110,
        CondNv = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic nzcv_t pack_nzcv(input logic n, input logic z, input logic c,
                                        input logic v);
        nzcv_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/ex_mem_flag_stage_cond_eval.sv
// Combinational evaluation of a 4-bit branch condition code against NZCV flags.
module ex_mem_flag_stage_cond_eval
    import ex_mem_flag_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CondEq: taken = z;
            CondNe: taken = !z;
            CondHs: taken = c;
            CondLo: taken = !c;
            CondMi: taken = n;
            CondPl: taken = !n;
            CondVs: taken = v;
            CondVc: taken = !v;
            CondHi: taken = c & !z;
            CondLs: taken = !c | z;
            CondGe: taken = (n == v);
            CondLt: taken = (n != v);
            CondGt: taken = !z & (n == v);
            CondLe: taken = z | (n != v);
            // NV behaves as always in this architecture.
            CondAl: taken = 1'b1;
            CondNv: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with architectural NZCV flags and registered branch resolution
// for B.cond / CBZ / CBNZ.
module ex_mem_flag_stage
    import ex_mem_flag_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_carry_out,
    input  logic                  set_flags,
    input  logic                  cond_branch,
    input  logic                  cbz,
    input  logic                  cbnz,
    input  logic [3:0]            cond,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     result_q,
    output logic [REG_ADDR_W-1:0] rd_q,
    output logic                  reg_write_q,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic                  branch_taken
);

    logic  cond_taken;
    logic  branch_d;
    nzcv_t alu_flags;

    // B.cond sees the flag register as it stands before this edge, never same-beat ALU flags.
    ex_mem_flag_stage_cond_eval u_cond_eval (
        .cond  (cond),
        .n     (flag_n),
        .z     (flag_z),
        .c     (flag_c),
        .v     (flag_v),
        .taken (cond_taken)
    );

    assign alu_flags = pack_nzcv(alu_negative, alu_zero, alu_carry_out, alu_overflow);

    // CBZ/CBNZ test the ALU zero of the PASS_B operand, not the flag register.
    always_comb begin
        branch_d = 1'b0;
        if (cond_branch) begin
            branch_d = cond_taken;
        end else if (cbz) begin
            branch_d = alu_zero;
        end else if (cbnz) begin
            branch_d = !alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            result_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            branch_taken <= 1'b0;
            flag_n       <= 1'b0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            flag_v       <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_taken <= 1'b0;
        end else if (stall) begin
            out_valid    <= out_valid;
        end else if (in_valid) begin
            out_valid    <= 1'b1;
            result_q     <= alu_result;
            rd_q         <= rd_in;
            reg_write_q  <= reg_write_in;
            branch_taken <= branch_d;
            if (set_flags) begin
                flag_n <= alu_flags.n;
                flag_z <= alu_flags.z;
                flag_c <= alu_flags.c;
                flag_v <= alu_flags.v;
            end
        end else begin
            out_valid    <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed bench for ex_mem_flag_stage: reset, flag/branch interplay, stall/flush, cond sweep.
module tb_ex_mem_flag_stage;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_negative;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  alu_carry_out;
    logic                  set_flags;
    logic                  cond_branch;
    logic                  cbz;
    logic                  cbnz;
    logic [3:0]            cond;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  reg_write_in;
    logic                  out_valid;
    logic [DATA_W-1:0]     result_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic                  flag_n;
    logic                  flag_z;
    logic                  flag_c;
    logic                  flag_v;
    logic                  branch_taken;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_flag_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .alu_result    (alu_result),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .set_flags     (set_flags),
        .cond_branch   (cond_branch),
        .cbz           (cbz),
        .cbnz          (cbnz),
        .cond          (cond),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .out_valid     (out_valid),
        .result_q      (result_q),
        .rd_q          (rd_q),
        .reg_write_q   (reg_write_q),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .branch_taken  (branch_taken)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; in_valid = 0; stall = 0; flush = 0;
        alu_result = '0; alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        set_flags = 0; cond_branch = 0; cbz = 0; cbnz = 0; cond = 4'h0;
        rd_in = '0; reg_write_in = 0;
    endtask

    // Set flags via an accepted flag-setting op; f = {N,Z,C,V}.
    task automatic drive_flags(input logic [3:0] f);
        clear_inputs();
        in_valid = 1; set_flags = 1;
        alu_negative = f[3]; alu_zero = f[2]; alu_carry_out = f[1]; alu_overflow = f[0];
    endtask

    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv, r;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: r = fz;
            3'd1: r = fc;
            3'd2: r = fn;
            3'd3: r = fv;
            3'd4: r = fc && !fz;
            3'd5: r = (fn == fv);
            3'd6: r = (fn == fv) && !fz;
            default: r = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) r = !r;
        return r;
    endfunction

    function automatic logic [3:0] nzcv();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    initial begin
        clear_inputs();

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            rst = 1;
            in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
            alu_result = {$urandom, $urandom};
            {alu_negative, alu_zero, alu_overflow, alu_carry_out} = 4'($urandom);
            {set_flags, cond_branch, cbz, cbnz} = 4'($urandom);
            cond = 4'($urandom); rd_in = 5'($urandom); reg_write_in = 1'($urandom);
            step();
        end
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_result", result_q, 0);
        check("rst_rd", 64'(rd_q), 0);
        check("rst_reg_write", 64'(reg_write_q), 0);
        check("rst_nzcv", 64'(nzcv()), 0);
        check("rst_branch", 64'(branch_taken), 0);

        // 2: SUBS then B.EQ
        clear_inputs();
        in_valid = 1; set_flags = 1; alu_result = '0; alu_zero = 1; alu_carry_out = 1;
        rd_in = 5'd3; reg_write_in = 1;
        step();
        check("subs_valid", 64'(out_valid), 1);
        check("subs_rd", 64'(rd_q), 3);
        check("subs_reg_write", 64'(reg_write_q), 1);
        check("subs_nzcv", 64'(nzcv()), 4'b0110);
        check("subs_branch", 64'(branch_taken), 0);
        clear_inputs();
        in_valid = 1; cond_branch = 1; cond = 4'b0000; alu_zero = 0;
        step();
        check("beq_branch", 64'(branch_taken), 1);
        check("beq_nzcv", 64'(nzcv()), 4'b0110);
        check("beq_reg_write", 64'(reg_write_q), 0);

        // 3: same-beat set_flags + B.EQ uses old Z
        drive_flags(4'b0000);
        step();
        check("clr_nzcv", 64'(nzcv()), 0);
        drive_flags(4'b0100);
        cond_branch = 1; cond = 4'b0000;
        step();
        check("samebeat_branch", 64'(branch_taken), 0);
        check("samebeat_nzcv", 64'(nzcv()), 4'b0100);

        // 4: CBZ / CBNZ on ALU zero
        clear_inputs();
        in_valid = 1; cbz = 1; alu_result = '0; alu_zero = 1;
        step();
        check("cbz_branch", 64'(branch_taken), 1);
        check("cbz_nzcv", 64'(nzcv()), 4'b0100);
        cbz = 0; cbnz = 1;
        step();
        check("cbnz_branch", 64'(branch_taken), 0);
        check("cbnz_nzcv", 64'(nzcv()), 4'b0100);

        // 5: stall holds everything; stall+flush kills
        drive_flags(4'b1010);
        alu_result = 64'hDEAD_BEEF; rd_in = 5'd7; reg_write_in = 1;
        cond_branch = 1; cond = 4'b1110;
        step();
        check("pre_stall_result", result_q, 64'hDEAD_BEEF);
        check("pre_stall_nzcv", 64'(nzcv()), 4'b1010);
        check("pre_stall_branch", 64'(branch_taken), 1);
        drive_flags(4'b0101);
        stall = 1; alu_result = 64'h1234; rd_in = 5'd9; reg_write_in = 0; cbnz = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_result", result_q, 64'hDEAD_BEEF);
            check("stall_rd", 64'(rd_q), 7);
            check("stall_nzcv", 64'(nzcv()), 4'b1010);
            check("stall_branch", 64'(branch_taken), 1);
            check("stall_valid", 64'(out_valid), 1);
        end
        flush = 1;
        step();
        check("flush_valid", 64'(out_valid), 0);
        check("flush_reg_write", 64'(reg_write_q), 0);
        check("flush_branch", 64'(branch_taken), 0);
        check("flush_nzcv", 64'(nzcv()), 4'b1010);

        // bubble
        clear_inputs();
        set_flags = 1; alu_zero = 1; reg_write_in = 1;
        step();
        check("bubble_valid", 64'(out_valid), 0);
        check("bubble_nzcv", 64'(nzcv()), 4'b1010);

        // 6: sweep all cond codes against all flag values
        for (int f = 0; f < 16; f++) begin
            drive_flags(4'(f));
            step();
            check("sweep_nzcv", 64'(nzcv()), 64'(f));
            for (int cc = 0; cc < 16; cc++) begin
                clear_inputs();
                in_valid = 1; cond_branch = 1; cond = 4'(cc);
                alu_zero = 1'(~f[2]);
                step();
                check($sformatf("cond_%0d_nzcv_%0d", cc, f), 64'(branch_taken),
                      64'(cond_model(4'(cc), 4'(f))));
            end
        end

        // reset in the middle of a stall clears everything
        drive_flags(4'b1111);
        alu_result = 64'hFFFF; rd_in = 5'd31; reg_write_in = 1; cbz = 1; alu_zero = 1;
        step();
        check("pre_rst_nzcv", 64'(nzcv()), 4'b1111);
        stall = 1;
        step();
        rst = 1;
        step();
        check("midrst_valid", 64'(out_valid), 0);
        check("midrst_result", result_q, 0);
        check("midrst_rd", 64'(rd_q), 0);
        check("midrst_reg_write", 64'(reg_write_q), 0);
        check("midrst_nzcv", 64'(nzcv()), 0);
        check("midrst_branch", 64'(branch_taken), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
